// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 main controller: sequences IF/ID/EXE/MEM/WB and decodes
// opcode/funct into ALU function code and datapath enables.
module mc_control_fsm #(
    parameter logic [5:0] HALT_OP = 6'h3F,
    parameter logic [4:0] RA_IDX  = 5'd31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [2:0] state,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_BAD, C_ALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_HALT
    } cls_t;

    // jal targets RA_IDX through the regfile mux; r0 would silently drop the link.
    if (RA_IDX == 5'd0) begin : g_ra_check
        $error("RA_IDX must not be register 0");
    end

    state_t     st;
    logic       ovf_q;
    cls_t       cls;
    logic [3:0] dec_op;
    logic       dec_sa;
    logic [1:0] dec_sb;
    logic [1:0] dec_rd;
    logic       dec_trap;

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        cls      = C_BAD;
        dec_op   = 4'b0000;
        dec_sa   = 1'b0;
        dec_sb   = 2'd0;
        dec_rd   = 2'd0;
        dec_trap = 1'b0;
        if (opcode == HALT_OP) begin
            cls = C_HALT;
        end else begin
            case (opcode)
                6'h00: begin
                    cls    = C_ALU;
                    dec_rd = 2'd1;
                    case (funct)
                        6'h00: begin dec_op = 4'b1010; dec_sa = 1'b1; end
                        6'h02: begin dec_op = 4'b1011; dec_sa = 1'b1; end
                        6'h20: begin dec_op = 4'b0100; dec_trap = 1'b1; end
                        6'h21: dec_op = 4'b0101;
                        6'h22: begin dec_op = 4'b0110; dec_trap = 1'b1; end
                        6'h23: dec_op = 4'b0111;
                        6'h24: dec_op = 4'b0000;
                        6'h25: dec_op = 4'b0001;
                        6'h26: dec_op = 4'b0010;
                        6'h27: dec_op = 4'b0011;
                        6'h2B: dec_op = 4'b1000;
                        default: cls = C_BAD;
                    endcase
                end
                6'h02: cls = C_J;
                6'h03: begin cls = C_JAL; dec_rd = 2'd2; end
                6'h04: begin cls = C_BR; dec_op = 4'b1100; end
                6'h05: begin cls = C_BR; dec_op = 4'b1111; end
                6'h06: begin cls = C_BR; dec_op = 4'b1110; end
                6'h07: begin cls = C_BR; dec_op = 4'b1101; end
                6'h08: begin cls = C_ALU; dec_op = 4'b0100; dec_sb = 2'd1; dec_trap = 1'b1; end
                6'h09: begin cls = C_ALU; dec_op = 4'b0101; dec_sb = 2'd1; end
                6'h0B: begin cls = C_ALU; dec_op = 4'b1000; dec_sb = 2'd2; end
                6'h0C: begin cls = C_ALU; dec_op = 4'b0000; dec_sb = 2'd2; end
                6'h0D: begin cls = C_ALU; dec_op = 4'b0001; dec_sb = 2'd2; end
                6'h0E: begin cls = C_ALU; dec_op = 4'b0010; dec_sb = 2'd2; end
                6'h0F: begin cls = C_ALU; dec_op = 4'b1001; dec_sb = 2'd1; end
                6'h23: begin cls = C_LW; dec_op = 4'b0101; dec_sb = 2'd1; end
                6'h2B: begin cls = C_SW; dec_op = 4'b0101; dec_sb = 2'd1; end
                default: cls = C_BAD;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st    <= S_IF;
            ovf_q <= 1'b0;
        end else begin
            case (st)
                S_IF: st <= S_ID;
                S_ID: begin
                    case (cls)
                        C_J, C_BAD: st <= S_IF;
                        C_JAL:      st <= S_WB;
                        C_HALT:     st <= S_HALT;
                        default:    st <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    ovf_q <= overflow;
                    case (cls)
                        C_ALU:      st <= S_WB;
                        C_LW, C_SW: st <= S_MEM;
                        default: begin
                            st    <= S_IF;
                            ovf_q <= 1'b0;
                        end
                    endcase
                end
                S_MEM: begin
                    if (cls == C_LW) begin
                        st <= S_WB;
                    end else begin
                        st    <= S_IF;
                        ovf_q <= 1'b0;
                    end
                end
                S_WB: begin
                    st    <= S_IF;
                    ovf_q <= 1'b0;
                end
                S_HALT: st <= S_HALT;
                default: begin
                    st    <= S_IF;
                    ovf_q <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

    always_comb begin
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        ir_write  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 4'b0000;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 2'd0;
        wb_sel    = 2'd0;
        halted    = 1'b0;
        // Datapath selects stay put from EXE through WB so the ALU result is stable at write-back.
        if (st == S_EXE || st == S_MEM || st == S_WB) begin
            alu_op    = dec_op;
            alu_src_a = dec_sa;
            alu_src_b = dec_sb;
            reg_dst   = dec_rd;
            wb_sel    = (cls == C_LW) ? 2'd1 : (cls == C_JAL) ? 2'd2 : 2'd0;
        end
        case (st)
            S_IF: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_ID: begin
                if (cls == C_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
            S_EXE: begin
                if (cls == C_BR) begin
                    pc_write = zero;
                    pc_src   = 2'd1;
                end
            end
            S_MEM: mem_write = (cls == C_SW);
            S_WB: begin
                reg_write = !(ovf_q && dec_trap);
                if (cls == C_JAL) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
        // A reset cycle must never commit architectural state.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver pushes a per-cycle expected trace
// derived from instruction class rules; a negedge monitor pops and compares.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       halted;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .state(state), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef enum int { K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_BAD, K_HALT } kind_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        kind_t      kind;
        logic [3:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic       rd;
        logic       trap;
    } ent_t;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       halted;
        logic [3:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] rdst;
        logic [1:0] wbs;
    } obs_t;

    typedef struct {
        obs_t  v;
        bit    c_pcs;
        bit    c_alu;
        bit    c_wb;
        string tag;
    } exp_t;

    ent_t tbl[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_ent(string n, logic [5:0] op, logic [5:0] fn, kind_t k,
                                    logic [3:0] aop, logic sa, logic [1:0] sb,
                                    logic rd, logic trap);
        ent_t e;
        e.name = n; e.op = op; e.fn = fn; e.kind = k; e.aop = aop;
        e.sa = sa; e.sb = sb; e.rd = rd; e.trap = trap;
        tbl.push_back(e);
    endfunction

    function automatic ent_t find(string n);
        foreach (tbl[i]) if (tbl[i].name == n) return tbl[i];
        return tbl[0];
    endfunction

    function automatic exp_t mk(logic [2:0] st, string tag);
        exp_t r;
        r.v = '0;
        r.v.st = st;
        r.c_pcs = 1'b0;
        r.c_alu = 1'b0;
        r.c_wb = 1'b0;
        r.tag = tag;
        return r;
    endfunction

    function automatic exp_t with_alu(exp_t r, ent_t e);
        r.v.aop = e.aop;
        r.v.sa = e.sa;
        r.v.sb = e.sb;
        r.c_alu = 1'b1;
        return r;
    endfunction

    // Expected per-cycle behaviour of one instruction, built from its class.
    function automatic int push_trace(ent_t e, bit z, bit ov);
        exp_t r;
        int n = 0;
        r = mk(3'd0, {e.name, "/IF"});
        r.v.pcw = 1'b1; r.v.irw = 1'b1; r.v.pcs = 2'd0; r.c_pcs = 1'b1;
        exp_q.push_back(r); n++;
        r = mk(3'd1, {e.name, "/ID"});
        if (e.kind == K_J) begin
            r.v.pcw = 1'b1; r.v.pcs = 2'd2; r.c_pcs = 1'b1;
        end
        exp_q.push_back(r); n++;
        case (e.kind)
            K_JAL: begin
                r = mk(3'd4, {e.name, "/WB"});
                r.v.pcw = 1'b1; r.v.pcs = 2'd2; r.c_pcs = 1'b1;
                r.v.regw = 1'b1; r.v.rdst = 2'd2; r.v.wbs = 2'd2; r.c_wb = 1'b1;
                exp_q.push_back(r); n++;
            end
            K_HALT: begin
                for (int i = 0; i < 8; i++) begin
                    r = mk(3'd7, {e.name, "/HALT"});
                    r.v.halted = 1'b1;
                    exp_q.push_back(r); n++;
                end
            end
            K_BR: begin
                r = with_alu(mk(3'd2, {e.name, "/EXE"}), e);
                r.v.pcw = z; r.v.pcs = 2'd1; r.c_pcs = 1'b1;
                exp_q.push_back(r); n++;
            end
            K_ALU, K_LW, K_SW: begin
                exp_q.push_back(with_alu(mk(3'd2, {e.name, "/EXE"}), e)); n++;
                if (e.kind != K_ALU) begin
                    r = with_alu(mk(3'd3, {e.name, "/MEM"}), e);
                    r.v.memw = (e.kind == K_SW);
                    exp_q.push_back(r); n++;
                end
                if (e.kind != K_SW) begin
                    r = with_alu(mk(3'd4, {e.name, "/WB"}), e);
                    r.v.regw = !(ov && e.trap);
                    r.v.rdst = e.rd ? 2'd1 : 2'd0;
                    r.v.wbs = (e.kind == K_LW) ? 2'd1 : 2'd0;
                    r.c_wb = 1'b1;
                    exp_q.push_back(r); n++;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    // stop < 0 runs the instruction to completion; otherwise leaves it after 'stop' cycles.
    task automatic issue_e(ent_t e, bit z, bit ov, int stop);
        int n;
        opcode = e.op;
        funct = (e.op == 6'h00) ? e.fn : 6'($urandom_range(0, 63));
        zero = z;
        overflow = ov;
        n = push_trace(e, z, ov);
        if (stop >= 0) n = stop;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(string name, bit z, bit ov);
        issue_e(find(name), z, ov, -1);
    endtask

    task automatic do_reset(int cycles, logic [2:0] first_state);
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("rst_strobes", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
            check("rst_state", 32'(state), (i == 0) ? 32'(first_state) : 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            obs_t act;
            obs_t msk;
            e = exp_q.pop_front();
            act.st = state; act.pcw = pc_write; act.pcs = pc_src; act.irw = ir_write;
            act.memw = mem_write; act.regw = reg_write; act.halted = halted;
            act.aop = alu_op; act.sa = alu_src_a; act.sb = alu_src_b;
            act.rdst = reg_dst; act.wbs = wb_sel;
            msk = '0;
            msk.st = '1; msk.pcw = 1'b1; msk.irw = 1'b1; msk.memw = 1'b1;
            msk.regw = 1'b1; msk.halted = 1'b1;
            if (e.c_pcs) msk.pcs = '1;
            if (e.c_alu) begin
                msk.aop = '1; msk.sa = 1'b1; msk.sb = '1;
            end
            if (e.c_wb) begin
                msk.rdst = '1; msk.wbs = '1;
            end
            check(e.tag, 32'(act & msk), 32'(e.v & msk));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t halt_e;
        int   n_rand;
        add_ent("add",   6'h00, 6'h20, K_ALU, 4'b0100, 1'b0, 2'd0, 1'b1, 1'b1);
        add_ent("addu",  6'h00, 6'h21, K_ALU, 4'b0101, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("sub",   6'h00, 6'h22, K_ALU, 4'b0110, 1'b0, 2'd0, 1'b1, 1'b1);
        add_ent("subu",  6'h00, 6'h23, K_ALU, 4'b0111, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("and",   6'h00, 6'h24, K_ALU, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("or",    6'h00, 6'h25, K_ALU, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("xor",   6'h00, 6'h26, K_ALU, 4'b0010, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("nor",   6'h00, 6'h27, K_ALU, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("sltu",  6'h00, 6'h2B, K_ALU, 4'b1000, 1'b0, 2'd0, 1'b1, 1'b0);
        add_ent("sll",   6'h00, 6'h00, K_ALU, 4'b1010, 1'b1, 2'd0, 1'b1, 1'b0);
        add_ent("srl",   6'h00, 6'h02, K_ALU, 4'b1011, 1'b1, 2'd0, 1'b1, 1'b0);
        add_ent("addi",  6'h08, 6'h00, K_ALU, 4'b0100, 1'b0, 2'd1, 1'b0, 1'b1);
        add_ent("addiu", 6'h09, 6'h00, K_ALU, 4'b0101, 1'b0, 2'd1, 1'b0, 1'b0);
        add_ent("sltiu", 6'h0B, 6'h00, K_ALU, 4'b1000, 1'b0, 2'd2, 1'b0, 1'b0);
        add_ent("andi",  6'h0C, 6'h00, K_ALU, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        add_ent("ori",   6'h0D, 6'h00, K_ALU, 4'b0001, 1'b0, 2'd2, 1'b0, 1'b0);
        add_ent("xori",  6'h0E, 6'h00, K_ALU, 4'b0010, 1'b0, 2'd2, 1'b0, 1'b0);
        add_ent("lui",   6'h0F, 6'h00, K_ALU, 4'b1001, 1'b0, 2'd1, 1'b0, 1'b0);
        add_ent("lw",    6'h23, 6'h00, K_LW,  4'b0101, 1'b0, 2'd1, 1'b0, 1'b0);
        add_ent("sw",    6'h2B, 6'h00, K_SW,  4'b0101, 1'b0, 2'd1, 1'b0, 1'b0);
        add_ent("beq",   6'h04, 6'h00, K_BR,  4'b1100, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("bne",   6'h05, 6'h00, K_BR,  4'b1111, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("blez",  6'h06, 6'h00, K_BR,  4'b1110, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("bgtz",  6'h07, 6'h00, K_BR,  4'b1101, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("j",     6'h02, 6'h00, K_J,   4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("jal",   6'h03, 6'h00, K_JAL, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("badfn", 6'h00, 6'h3F, K_BAD, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("badop", 6'h10, 6'h00, K_BAD, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        add_ent("badop1",6'h01, 6'h00, K_BAD, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        n_rand = tbl.size();
        add_ent("halt",  6'h3F, 6'h00, K_HALT, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        halt_e = find("halt");

        do_reset(2, 3'd0);

        issue("add", 1'b0, 1'b0);
        issue("add", 1'b0, 1'b1);
        issue("addu", 1'b0, 1'b1);
        issue("sub", 1'b1, 1'b1);
        issue("addi", 1'b0, 1'b1);
        issue("beq", 1'b1, 1'b0);
        issue("bne", 1'b0, 1'b0);
        issue("bgtz", 1'b1, 1'b1);
        issue("blez", 1'b0, 1'b0);
        issue("lw", 1'b0, 1'b1);
        issue("sw", 1'b1, 1'b0);
        issue("jal", 1'b0, 1'b1);
        issue("j", 1'b1, 1'b0);
        issue("sll", 1'b0, 1'b0);
        issue("lui", 1'b0, 1'b0);
        issue("sltiu", 1'b0, 1'b0);
        issue("badfn", 1'b0, 1'b0);
        issue("badop", 1'b1, 1'b1);

        for (int i = 0; i < 250; i++) begin
            issue_e(tbl[$urandom_range(0, n_rand - 1)], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end

        issue_e(find("sw"), 1'b0, 1'b0, 3);
        do_reset(2, 3'd3);
        issue_e(find("lw"), 1'b0, 1'b1, 2);
        do_reset(2, 3'd2);
        issue_e(find("add"), 1'b0, 1'b0, 0);
        do_reset(1, 3'd0);
        issue("add", 1'b0, 1'b1);
        issue_e(halt_e, 1'b0, 1'b0, -1);
        do_reset(2, 3'd7);
        issue("addu", 1'b0, 1'b0);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
